pixel_packer_tx: RTL and testbench

PIXEL_PACKER_TX -- requirements
Module: pixel_packer_tx

---
 rtl/pixel_packer_tx.sv | 154 +++++++++++++++
 tb/tb_pixel_packer_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_packer_tx.sv
// pixel_packer_tx: packs NB_PIXEL-wide convolved pixels into NB_DATA-wide
// words with a valid/ready output stage. A word closes when its last lane
// fills or when the column ends. A column-end word has its unfilled lanes
// zeroed and is flagged with o_last.
// Ports:
//   i_clk          clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_pixel        input pixel
//   i_pixel_valid  i_pixel valid this cycle
//   o_pixel_ready  block accepts a pixel this cycle
//   o_axi_data     packed output word (lane 0 in the MSBs)
//   o_valid        o_axi_data holds a word
//   i_ready        downstream accepts the word this cycle
//   o_last         final word of a column, qualified by o_valid
module pixel_packer_tx #(
  parameter int unsigned IMAGE_HEIGHT = 200,
  parameter int unsigned NB_PIXEL     = 8,
  parameter int unsigned NB_DATA      = 32,
  parameter int unsigned COL_LEN      = IMAGE_HEIGHT - 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NB_PIXEL-1:0] i_pixel,
  input  logic                i_pixel_valid,
  output logic                o_pixel_ready,
  output logic [NB_DATA-1:0]  o_axi_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_last
);

  localparam int unsigned LANES  = NB_DATA / NB_PIXEL;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned COL_W  = (COL_LEN > 1) ? $clog2(COL_LEN) : 1;

  typedef enum logic {S_FILL, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [NB_DATA-1:0]  pack_q, pack_d;
  logic                hold_last_q, hold_last_d;
  logic [NB_DATA-1:0]  out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                rdy_q, rdy_d;

  logic                accept_c;
  logic                xfer_c;
  logic                col_end_c;
  logic                word_done_c;
  logic [NB_DATA-1:0]  word_new_c;

  assign accept_c    = i_pixel_valid & rdy_q;
  assign xfer_c      = out_valid_q & i_ready;
  assign col_end_c   = (col_q == COL_W'(COL_LEN - 1));
  assign word_done_c = (lane_q == LANE_W'(LANES - 1)) | col_end_c;

  // Pack register is zero past the current lane, so OR-ing the new pixel
  // into its slot also leaves unfilled lanes zero on a column-end word.
  always_comb begin
    word_new_c = pack_q;
    for (int l = 0; l < int'(LANES); l++) begin
      if (lane_q == LANE_W'(l)) begin
        word_new_c[NB_DATA - 1 - l * NB_PIXEL -: NB_PIXEL] = i_pixel;
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    col_d       = col_q;
    pack_d      = pack_q;
    hold_last_d = hold_last_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    // A transfer empties the output register unless a word loads below.
    if (xfer_c) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_FILL: begin
        if (accept_c) begin
          col_d = col_end_c ? '0 : col_q + COL_W'(1);
          if (word_done_c) begin
            lane_d = '0;
            if (!out_valid_q || xfer_c) begin
              out_data_d  = word_new_c;
              out_valid_d = 1'b1;
              out_last_d  = col_end_c;
              pack_d      = '0;
            end else begin
              // Output busy: park the finished word and stop accepting.
              pack_d      = word_new_c;
              hold_last_d = col_end_c;
              state_d     = S_HOLD;
            end
          end else begin
            pack_d = word_new_c;
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (xfer_c) begin
          out_data_d  = pack_q;
          out_valid_d = 1'b1;
          out_last_d  = hold_last_q;
          pack_d      = '0;
          state_d     = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase

    rdy_d = (state_d == S_FILL);
  end

  // State register; ready is held low throughout reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_FILL;
      lane_q      <= '0;
      col_q       <= '0;
      pack_q      <= '0;
      hold_last_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      col_q       <= col_d;
      pack_q      <= pack_d;
      hold_last_q <= hold_last_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      rdy_q       <= rdy_d;
    end
  end

  assign o_pixel_ready = rdy_q;
  assign o_axi_data    = out_data_q;
  assign o_valid       = out_valid_q;
  assign o_last        = out_last_q;

endmodule

// File: tb/tb_pixel_packer_tx.sv
// tb_pixel_packer_tx: bench for pixel_packer_tx with a queue-based packing
// model, a per-cycle output checker and directed plus random scenarios.
module tb_pixel_packer_tx;

  localparam int unsigned NB_PIXEL = 8;
  localparam int unsigned NB_DATA  = 32;
  localparam int unsigned LANES    = NB_DATA / NB_PIXEL;
  localparam int unsigned COL_LEN  = 198;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NB_PIXEL-1:0] pix = '0;
  logic                pvalid = 1'b0;
  logic                pready;
  logic [NB_DATA-1:0]  odata;
  logic                ovalid;
  logic                rdy = 1'b0;
  logic                olast;

  int total = 0;
  int bad   = 0;

  pixel_packer_tx #(
    .IMAGE_HEIGHT(200),
    .NB_PIXEL(NB_PIXEL),
    .NB_DATA(NB_DATA),
    .COL_LEN(COL_LEN)
  ) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_pixel(pix),
    .i_pixel_valid(pvalid),
    .o_pixel_ready(pready),
    .o_axi_data(odata),
    .o_valid(ovalid),
    .i_ready(rdy),
    .o_last(olast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pixels collected per word, column position, expected words.
  logic [NB_PIXEL-1:0] mpix[$];
  int                  mcol = 0;
  logic [NB_DATA:0]    mq[$];
  logic [NB_DATA:0]    got[$];

  logic                stall_prev = 1'b0;
  logic [NB_DATA-1:0]  prev_data;
  logic                prev_last;

  logic                win = 1'b0;
  int                  cyc = 0;
  int                  rdlow = 0;
  int                  stamps[$];

  // Observe at negedge: these inputs/outputs decide the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      mpix.delete();
      mq.delete();
      mcol = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 64'(ovalid), 64'(1));
        chk("stall_data", 64'(odata), 64'(prev_data));
        chk("stall_last", 64'(olast), 64'(prev_last));
      end
      if (ovalid && rdy) begin
        if (mq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h expected none", odata);
        end else begin
          logic [NB_DATA:0] e;
          e = mq.pop_front();
          chk("word_data", 64'(odata), 64'(e[NB_DATA-1:0]));
          chk("word_last", 64'(olast), 64'(e[NB_DATA]));
        end
        got.push_back({olast, odata});
      end
      if (pvalid && pready) begin
        mpix.push_back(pix);
        if (mpix.size() == LANES || mcol == int'(COL_LEN) - 1) begin
          logic [NB_DATA-1:0] w;
          w = '0;
          for (int k = 0; k < mpix.size(); k++)
            w = w | (NB_DATA'(mpix[k]) << (NB_PIXEL * (LANES - 1 - k)));
          mq.push_back({(mcol == int'(COL_LEN) - 1), w});
          mpix.delete();
        end
        mcol = (mcol == int'(COL_LEN) - 1) ? 0 : mcol + 1;
      end
      stall_prev = ovalid && !rdy;
      prev_data  = odata;
      prev_last  = olast;
      if (win) begin
        if (!pready) rdlow++;
        if (ovalid) stamps.push_back(cyc);
        cyc++;
      end
    end
  end

  logic rand_rdy = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) rdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [NB_PIXEL-1:0] p);
    logic ok;
    int   n;
    n = 0;
    ok = 1'b0;
    pvalid = 1'b1;
    pix = p;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = pready;
      tick();
      n++;
    end
    pvalid = 1'b0;
    if (!ok) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    pvalid = 1'b0;
    #1;
    chk("rst_valid", 64'(ovalid), 64'(0));
    chk("rst_last", 64'(olast), 64'(0));
    chk("rst_data", 64'(odata), 64'(0));
    chk("rst_ready", 64'(pready), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    got.delete();
    tick();
    chk("ready_after_rst", 64'(pready), 64'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_rdy = 1'b0;
    #0;
    rdy = 1'b1;
    while ((mq.size() != 0 || ovalid) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_empty", 64'(mq.size()), 64'(0));
    chk("drain_idle", 64'(ovalid), 64'(0));
  endtask

  initial begin
    int lasts;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single word, latency and lane order.
    do_reset();
    rdy = 1'b1;
    send(8'hFF); send(8'h0F); send(8'h01);
    chk("pre_word_valid", 64'(ovalid), 64'(0));
    send(8'h08);
    chk("lat_valid", 64'(ovalid), 64'(1));
    chk("lat_data", 64'(odata), 64'(32'hFF0F0108));
    chk("lat_last", 64'(olast), 64'(0));
    drain();

    // Full column with a partial last word.
    do_reset();
    rdy = 1'b1;
    for (int n = 0; n < int'(COL_LEN); n++) send(NB_PIXEL'(n));
    drain();
    chk("col_words", 64'(got.size()), 64'(50));
    if (got.size() == 50) begin
      chk("col_first", 64'(got[0]), 64'({1'b0, 32'h00010203}));
      chk("col_final", 64'(got[49]), 64'({1'b1, 32'hC4C50000}));
      lasts = 0;
      for (int i = 0; i < 49; i++) lasts += int'(got[i][NB_DATA]);
      chk("col_early_last", 64'(lasts), 64'(0));
    end

    // Backpressure: two words stack up, ready drops, then both drain in order.
    do_reset();
    rdy = 1'b0;
    for (int n = 1; n <= 8; n++) send(NB_PIXEL'(n));
    chk("hold_ready", 64'(pready), 64'(0));
    chk("hold_valid", 64'(ovalid), 64'(1));
    chk("hold_data", 64'(odata), 64'(32'h01020304));
    drain();
    chk("bp_words", 64'(got.size()), 64'(2));
    if (got.size() == 2) begin
      chk("bp_w0", 64'(got[0]), 64'({1'b0, 32'h01020304}));
      chk("bp_w1", 64'(got[1]), 64'({1'b0, 32'h05060708}));
    end
    chk("bp_ready_back", 64'(pready), 64'(1));

    // Reset mid-word discards partial data.
    do_reset();
    rdy = 1'b1;
    send(8'hAA); send(8'hBB);
    do_reset();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    drain();
    chk("rst_words", 64'(got.size()), 64'(1));
    if (got.size() == 1) chk("rst_word", 64'(got[0]), 64'({1'b0, 32'h11223344}));

    // Streaming throughput.
    do_reset();
    rdy = 1'b1;
    stamps.delete();
    rdlow = 0;
    cyc = 0;
    win = 1'b1;
    for (int n = 0; n < 40; n++) send(NB_PIXEL'($urandom));
    tick();
    tick();
    win = 1'b0;
    chk("stream_ready_low", 64'(rdlow), 64'(0));
    chk("stream_words", 64'(stamps.size()), 64'(10));
    for (int i = 1; i < stamps.size(); i++)
      chk("stream_period", 64'(stamps[i] - stamps[i-1]), 64'(4));
    drain();

    // Random ready and valid gaps across several columns.
    do_reset();
    rand_rdy = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send(NB_PIXEL'($urandom));
    end
    drain();
    chk("rand_words", 64'(got.size()), 64'(1000 / 198 * 50 + 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
